// File: rtl/control_sequencer_if.sv
// control_sequencer_if: IR/memory handshake and datapath control strobes between sequencer and datapath
interface control_sequencer_if;
    logic [31:0] ir;
    logic        mem_ready;
    logic        PCout, Zlowout, MDRout, Cout;
    logic        MARin, PCin, MDRin, IRin, Yin, Zin;
    logic        IncPC, Read, Write;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic [3:0]  alu_op;
    logic        run, fault;

    modport master (
        input  ir, mem_ready,
        output PCout, Zlowout, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin, Zin,
        output IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, alu_op, run, fault
    );

    modport slave (
        output ir, mem_ready,
        input  PCout, Zlowout, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin, Zin,
        input  IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, alu_op, run, fault
    );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: Mini-SRC fetch/decode/execute T-state sequencer with memory wait timeout
module control_sequencer #(
    parameter int WAIT_MAX = 15
) (
    input logic clk,
    input logic reset_n,
    control_sequencer_if.master bus
);
    localparam logic [3:0] T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3, T4 = 4'd4;
    localparam logic [3:0] T5 = 4'd5, T6 = 4'd6, T7 = 4'd7, HALT = 4'd8;
    localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010;
    localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b01010, OP_OR = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI = 5'b01110, OP_HALT = 5'b11011;
    localparam int CW = $clog2(WAIT_MAX + 1);

    logic [3:0]    state, nxt;
    logic [4:0]    op, op_q;
    logic [CW-1:0] cnt;
    logic [7:0]    t;
    logic [3:0]    alu_code;
    logic          fault_q, alu3, imm, ldi, ld, st, mem_op, exec, wait_st, timeout;
    logic          unused_ir;

    assign unused_ir = ^bus.ir[26:0];
    // The opcode is taken live from IR in T3 and held afterwards so execute states do not depend on IR changes
    assign op      = (state == T3) ? bus.ir[31:27] : op_q;
    assign alu3    = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
    assign imm     = op inside {OP_ADDI, OP_ANDI, OP_ORI};
    assign ldi     = op == OP_LDI;
    assign ld      = op == OP_LD;
    assign st      = op == OP_ST;
    assign mem_op  = ld | st;
    assign exec    = alu3 | imm | ldi | mem_op;
    assign wait_st = (state == T1) | ((state == T6) & ld) | ((state == T7) & st);
    // A late mem_ready on the final allowed cycle still completes the access
    assign timeout = wait_st & ~bus.mem_ready & (cnt == CW'(WAIT_MAX - 1));

    // Next T-state; wait states hold until mem_ready
    always_comb begin
        nxt = HALT;
        case (state)
            T0: nxt = T1;
            T1: nxt = bus.mem_ready ? T2 : T1;
            T2: nxt = T3;
            T3: nxt = (op == OP_HALT) ? HALT : exec ? T4 : T0;
            T4: nxt = T5;
            T5: nxt = mem_op ? T6 : T0;
            T6: nxt = (st | bus.mem_ready) ? T7 : T6;
            T7: nxt = (ld | bus.mem_ready) ? T0 : T7;
            default: nxt = HALT;
        endcase
    end

    // State, opcode latch, wait counter and sticky fault
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= T0;
            op_q    <= '0;
            cnt     <= '0;
            fault_q <= 1'b0;
        end else begin
            state   <= timeout ? HALT : nxt;
            op_q    <= op;
            cnt     <= (wait_st & ~bus.mem_ready & ~timeout) ? cnt + CW'(1) : '0;
            fault_q <= fault_q | timeout;
        end
    end

    // One-hot T-state decode, forced low while reset is asserted so strobes drop immediately
    always_comb begin
        t = '0;
        for (int i = 0; i < 8; i++) t[i] = reset_n && (state == 4'(i));
    end

    assign alu_code = (op == OP_SUB) ? 4'd2 :
                      (op == OP_AND || op == OP_ANDI) ? 4'd3 :
                      (op == OP_OR || op == OP_ORI) ? 4'd4 : 4'd1;

    assign bus.PCout   = t[0];
    assign bus.MARin   = t[0] | (t[5] & mem_op);
    assign bus.IncPC   = t[0];
    assign bus.Zin     = t[0] | t[4];
    assign bus.Zlowout = t[1] | t[5];
    assign bus.PCin    = t[1];
    assign bus.Read    = t[1] | (t[6] & ld);
    assign bus.MDRin   = t[1] | t[6];
    assign bus.MDRout  = t[2] | (t[7] & ld);
    assign bus.IRin    = t[2];
    assign bus.Yin     = t[3] & exec;
    assign bus.Grb     = t[3] & exec;
    assign bus.BAout   = t[3] & (ldi | mem_op);
    assign bus.Rout    = (t[3] & (alu3 | imm)) | (t[4] & alu3) | (t[6] & st);
    assign bus.Grc     = t[4] & alu3;
    assign bus.Cout    = t[4] & (imm | ldi | mem_op);
    assign bus.alu_op  = t[4] ? alu_code : 4'd0;
    assign bus.Gra     = (t[5] & (alu3 | imm | ldi)) | (t[6] & st) | (t[7] & ld);
    assign bus.Rin     = (t[5] & (alu3 | imm | ldi)) | (t[7] & ld);
    assign bus.Write   = t[7] & st;
    assign bus.run     = reset_n && (state != HALT);
    assign bus.fault   = fault_q;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed scoreboard bench for the Mini-SRC control sequencer
module tb_control_sequencer;
    localparam logic [24:0] PCO = 25'd1 << 24, ZLO = 25'd1 << 23, MDRO = 25'd1 << 22, COUT = 25'd1 << 21;
    localparam logic [24:0] MARI = 25'd1 << 20, PCI = 25'd1 << 19, MDRI = 25'd1 << 18, IRI = 25'd1 << 17;
    localparam logic [24:0] YIN = 25'd1 << 16, ZIN = 25'd1 << 15, INCPC = 25'd1 << 14, RD = 25'd1 << 13;
    localparam logic [24:0] WR = 25'd1 << 12, GRA = 25'd1 << 11, GRB = 25'd1 << 10, GRC = 25'd1 << 9;
    localparam logic [24:0] RIN = 25'd1 << 8, ROUT = 25'd1 << 7, BAO = 25'd1 << 6, RUN = 25'd2, FLT = 25'd1;
    localparam logic [24:0] V_NONE = 25'd0;
    localparam logic [24:0] V_T0 = PCO | MARI | INCPC | ZIN | RUN;
    localparam logic [24:0] V_T1 = ZLO | PCI | RD | MDRI | RUN;
    localparam logic [24:0] V_T2 = MDRO | IRI | RUN;
    localparam logic [24:0] V_T3R = GRB | ROUT | YIN | RUN;
    localparam logic [24:0] V_T3M = GRB | BAO | YIN | RUN;
    localparam logic [24:0] V_T5W = ZLO | GRA | RIN | RUN;
    localparam logic [24:0] V_T5M = ZLO | MARI | RUN;
    localparam logic [24:0] V_T6L = RD | MDRI | RUN;
    localparam logic [24:0] V_T7L = MDRO | GRA | RIN | RUN;
    localparam logic [24:0] V_T6S = GRA | ROUT | MDRI | RUN;
    localparam logic [24:0] V_T7S = WR | RUN;

    logic clk = 1'b0;
    logic reset_n;
    logic [24:0] vec;
    logic [24:0] exp_q[$];
    string tag_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    control_sequencer_if bus();
    control_sequencer #(.WAIT_MAX(15)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    assign vec = {bus.PCout, bus.Zlowout, bus.MDRout, bus.Cout, bus.MARin, bus.PCin, bus.MDRin, bus.IRin,
                  bus.Yin, bus.Zin, bus.IncPC, bus.Read, bus.Write, bus.Gra, bus.Grb, bus.Grc, bus.Rin,
                  bus.Rout, bus.BAout, bus.alu_op, bus.run, bus.fault};

    function automatic logic [24:0] t4r(input int n);
        return GRC | ROUT | ZIN | RUN | (25'(n) << 2);
    endfunction

    function automatic logic [24:0] t4i(input int n);
        return COUT | ZIN | RUN | (25'(n) << 2);
    endfunction

    task automatic check(input string tag, input logic [24:0] got, input logic [24:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Monitor: every cycle with a queued expectation is compared mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) check(tag_q.pop_front(), vec, exp_q.pop_front());
    end

    task automatic step(input logic [24:0] exp, input logic mr, input string tag);
        bus.mem_ready = mr;
        exp_q.push_back(exp);
        tag_q.push_back($sformatf("%s@%0d", tag, cyc));
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc = 0;
        step(V_NONE, 1'b1, "reset");
        reset_n = 1'b1;
    endtask

    task automatic fetch(input logic [31:0] ir, input string tag);
        bus.ir = ir;
        step(V_T0, 1'b1, tag);
        step(V_T1, 1'b1, tag);
        step(V_T2, 1'b1, tag);
    endtask

    logic [31:0] r_ir[4] = '{32'h18A18000, 32'h20000000, 32'h50000000, 32'h58000000};
    logic [31:0] i_ir[3] = '{32'h60000000, 32'h68000000, 32'h70000000};
    int r_alu[4] = '{1, 2, 3, 4};
    int i_alu[3] = '{1, 3, 4};

    initial begin
        reset_n = 1'b0;
        bus.mem_ready = 1'b0;
        bus.ir = '0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            do_reset();
            fetch(r_ir[k], "reg3");
            step(V_T3R, 1'b1, "reg3");
            step(t4r(r_alu[k]), 1'b1, "reg3");
            step(V_T5W, 1'b1, "reg3");
            step(V_T0, 1'b1, "reg3");
        end
        for (int k = 0; k < 3; k++) begin
            do_reset();
            fetch(i_ir[k], "imm");
            step(V_T3R, 1'b1, "imm");
            step(t4i(i_alu[k]), 1'b1, "imm");
            step(V_T5W, 1'b1, "imm");
            step(V_T0, 1'b1, "imm");
        end
        do_reset();
        fetch(32'h08000000, "ldi");
        step(V_T3M, 1'b1, "ldi");
        step(t4i(1), 1'b1, "ldi");
        step(V_T5W, 1'b1, "ldi");
        step(V_T0, 1'b1, "ldi");
        do_reset();
        bus.ir = 32'h00400005;
        step(V_T0, 1'b0, "ld");
        for (int k = 0; k < 3; k++) step(V_T1, 1'b0, "ld");
        step(V_T1, 1'b1, "ld");
        step(V_T2, 1'b0, "ld");
        step(V_T3M, 1'b0, "ld");
        step(t4i(1), 1'b0, "ld");
        step(V_T5M, 1'b0, "ld");
        step(V_T6L, 1'b0, "ld");
        step(V_T6L, 1'b0, "ld");
        step(V_T6L, 1'b1, "ld");
        step(V_T7L, 1'b0, "ld");
        step(V_T0, 1'b0, "ld");
        do_reset();
        fetch(32'h10000000, "st");
        step(V_T3M, 1'b1, "st");
        step(t4i(1), 1'b1, "st");
        step(V_T5M, 1'b1, "st");
        step(V_T6S, 1'b1, "st");
        step(V_T7S, 1'b0, "st");
        step(V_T7S, 1'b0, "st");
        step(V_T7S, 1'b1, "st");
        step(V_T0, 1'b1, "st");
        do_reset();
        fetch(32'hD8000000, "halt");
        step(RUN, 1'b1, "halt");
        for (int k = 0; k < 20; k++) step(V_NONE, k[0], "halted");
        do_reset();
        fetch(32'hD0000000, "nop");
        step(RUN, 1'b1, "nop");
        step(V_T0, 1'b1, "nop");
        do_reset();
        fetch(32'hF8000000, "unlisted");
        step(RUN, 1'b1, "unlisted");
        step(V_T0, 1'b1, "unlisted");
        do_reset();
        bus.ir = 32'hD0000000;
        step(V_T0, 1'b0, "tmo");
        for (int k = 0; k < 15; k++) step(V_T1, 1'b0, "tmo");
        step(FLT, 1'b1, "tmo_fault");
        step(FLT, 1'b0, "tmo_fault");
        do_reset();
        bus.ir = 32'h00000000;
        step(V_T0, 1'b0, "late");
        for (int k = 0; k < 14; k++) step(V_T1, 1'b0, "late");
        step(V_T1, 1'b1, "late");
        step(V_T2, 1'b0, "late");
        step(V_T3M, 1'b0, "late");
        step(t4i(1), 1'b0, "late");
        step(V_T5M, 1'b0, "late");
        for (int k = 0; k < 14; k++) step(V_T6L, 1'b0, "late");
        step(V_T6L, 1'b1, "late");
        step(V_T7L, 1'b0, "late");
        step(V_T0, 1'b0, "late");
        do_reset();
        fetch(32'h00000000, "mid");
        step(V_T3M, 1'b1, "mid");
        step(t4i(1), 1'b1, "mid");
        step(V_T5M, 1'b1, "mid");
        bus.mem_ready = 1'b0;
        #1;
        check("mid_t6", vec, V_T6L);
        reset_n = 1'b0;
        #1;
        check("mid_async", vec, V_NONE);
        @(posedge clk);
        #1;
        step(V_NONE, 1'b0, "mid_rst");
        reset_n = 1'b1;
        step(V_T0, 1'b1, "mid_rel");
        step(V_T1, 1'b1, "mid_rel");
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
